// File: rtl/ioexp_pkg.sv
// Shared definitions for the IOExpansion transmit path: control byte, ASCII bases,
// formatter FSM states and the nibble-to-hex-character helper.
package ioexp_pkg;

    localparam logic [7:0] CLEAR_CHAR       = 8'h07;
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_UPPER_BASE = 8'h41;
    localparam logic [7:0] ASCII_LOWER_BASE = 8'h61;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SEND  = 2'd2
    } tx_state_t;

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib, input logic upper);
        logic [7:0] nib8;
        nib8 = {4'h0, nib};
        if (nib < 4'd10)
            return ASCII_DIGIT_BASE + nib8;
        else if (upper)
            return ASCII_UPPER_BASE + nib8 - 8'd10;
        else
            return ASCII_LOWER_BASE + nib8 - 8'd10;
    endfunction

endpackage

// File: rtl/hex_word_tx_if.sv
// Result-word / TX-FIFO side signals of the hex word formatter.
interface hex_word_tx_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_in;
    logic              resend;
    logic              tx_fifo_full;
    logic [7:0]        tx_din;
    logic              tx_write_en;
    logic              busy;
    logic              word_sent;

    modport master (
        output word_in, resend, tx_fifo_full,
        input  tx_din, tx_write_en, busy, word_sent
    );

    modport slave (
        input  word_in, resend, tx_fifo_full,
        output tx_din, tx_write_en, busy, word_sent
    );
endinterface

// File: rtl/hex_serializer.sv
// Holds the captured word and the character index; presents the ASCII hex
// character of the current nibble, most-significant nibble first.
module hex_serializer
    import ioexp_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter bit UPPERCASE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              advance,
    output logic [7:0]        ascii,
    output logic              idx_last
);
    localparam int NIB_N = WORD_W / 4;
    localparam int IDX_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;

    logic [WORD_W-1:0] snap_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [3:0]        nibs [NIB_N];

    // nibs[0] is the leftmost hex digit of the word
    generate
        for (genvar gi = 0; gi < NIB_N; gi++) begin : g_nib
            assign nibs[gi] = snap_reg[WORD_W-1-4*gi -: 4];
        end
    endgenerate

    assign idx_last = (idx_reg == IDX_W'(NIB_N - 1));
    assign ascii    = nib_to_ascii(nibs[idx_reg], UPPERCASE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_reg <= '0;
            idx_reg  <= '0;
        end else if (load) begin
            snap_reg <= load_word;
            idx_reg  <= '0;
        end else if (advance) begin
            idx_reg  <= idx_last ? '0 : idx_reg + 1'b1;
        end
    end

endmodule

// File: rtl/hex_word_tx.sv
// Watches a result word and, on change or resend request, writes a clear byte
// followed by the word as hex characters into the UART TX FIFO.
module hex_word_tx #(
    parameter int         WORD_W     = 32,
    parameter logic [7:0] CLEAR_CHAR = 8'h07,
    parameter bit         UPPERCASE  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    hex_word_tx_if.slave  bus
);
    import ioexp_pkg::*;

    tx_state_t         state_reg, state_next;
    logic [WORD_W-1:0] last_word_reg;
    logic              resend_pend_reg;
    logic              word_sent_reg;

    logic              start;
    logic              advance;
    logic              idx_last;
    logic [7:0]        char_ascii;
    logic [7:0]        tx_din_c;
    logic              tx_write_en_c;

    assign start = (state_reg == IDLE) &&
                   ((bus.word_in != last_word_reg) || resend_pend_reg || bus.resend);

    hex_serializer #(
        .WORD_W    (WORD_W),
        .UPPERCASE (UPPERCASE)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (start),
        .load_word (bus.word_in),
        .advance   (advance),
        .ascii     (char_ascii),
        .idx_last  (idx_last)
    );

    always_comb begin
        state_next    = state_reg;
        tx_din_c      = 8'h00;
        tx_write_en_c = 1'b0;
        advance       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start)
                    state_next = CLEAR;
            end
            CLEAR: begin
                tx_din_c      = CLEAR_CHAR;
                tx_write_en_c = !bus.tx_fifo_full;
                if (!bus.tx_fifo_full)
                    state_next = SEND;
            end
            SEND: begin
                tx_din_c      = char_ascii;
                tx_write_en_c = !bus.tx_fifo_full;
                if (!bus.tx_fifo_full) begin
                    advance = 1'b1;
                    if (idx_last)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            last_word_reg   <= '0;
            resend_pend_reg <= 1'b0;
            word_sent_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            word_sent_reg <= advance && idx_last;
            if (start)
                last_word_reg <= bus.word_in;
            // a request arriving mid-frame is remembered and served on return to IDLE
            resend_pend_reg <= start ? 1'b0 : (resend_pend_reg | bus.resend);
        end
    end

    assign bus.tx_din      = tx_din_c;
    assign bus.tx_write_en = tx_write_en_c;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.word_sent   = word_sent_reg;

endmodule
